// File: rtl/cfs_apb_arb.sv
// Two-requester round-robin APB arbiter in front of a single APB completer.
// Runs the downstream SETUP/ACCESS sequence and terminates stalled transfers with a watchdog.
module cfs_apb_arb #(
  parameter int unsigned APB_ADDR_WIDTH = 16,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [APB_ADDR_WIDTH-1:0] m0_paddr,
  input  logic                      m0_pwrite,
  input  logic                      m0_psel,
  input  logic                      m0_penable,
  input  logic [APB_DATA_WIDTH-1:0] m0_pwdata,
  output logic                      m0_pready,
  output logic [APB_DATA_WIDTH-1:0] m0_prdata,
  output logic                      m0_pslverr,
  input  logic [APB_ADDR_WIDTH-1:0] m1_paddr,
  input  logic                      m1_pwrite,
  input  logic                      m1_psel,
  input  logic                      m1_penable,
  input  logic [APB_DATA_WIDTH-1:0] m1_pwdata,
  output logic                      m1_pready,
  output logic [APB_DATA_WIDTH-1:0] m1_prdata,
  output logic                      m1_pslverr,
  output logic [APB_ADDR_WIDTH-1:0] s_paddr,
  output logic                      s_pwrite,
  output logic                      s_psel,
  output logic                      s_penable,
  output logic [APB_DATA_WIDTH-1:0] s_pwdata,
  input  logic                      s_pready,
  input  logic [APB_DATA_WIDTH-1:0] s_prdata,
  input  logic                      s_pslverr,
  output logic                      arb_busy,
  output logic                      arb_gnt,
  output logic                      timeout_evt
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                    state, state_nxt;
  logic                      last_grant;
  logic [CNT_W-1:0]          cnt;
  logic                      grant, pick, done_ok, done_tmo, rsp_err;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata;

  // Requester penable carries no information for the arbiter; psel alone is a request.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    pick      = 1'b0;
    done_ok   = 1'b0;
    done_tmo  = 1'b0;
    case (state)
      IDLE: begin
        if (m0_psel || m1_psel) begin
          grant     = 1'b1;
          pick      = (m0_psel && m1_psel) ? ~last_grant : m1_psel;
          state_nxt = SETUP;
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (s_pready) begin
          done_ok   = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          done_tmo  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    rsp_rdata = (done_ok && !s_pwrite) ? s_prdata : '0;
    rsp_err   = done_ok ? s_pslverr : 1'b1;
  end

  // Every output is registered from the next-state decode so it lines up with the state it describes.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      s_paddr     <= '0;
      s_pwrite    <= 1'b0;
      s_pwdata    <= '0;
      s_psel      <= 1'b0;
      s_penable   <= 1'b0;
      arb_busy    <= 1'b0;
      arb_gnt     <= 1'b0;
      last_grant  <= 1'b1;
      timeout_evt <= 1'b0;
      cnt         <= '0;
      m0_pready   <= 1'b0;
      m0_prdata   <= '0;
      m0_pslverr  <= 1'b0;
      m1_pready   <= 1'b0;
      m1_prdata   <= '0;
      m1_pslverr  <= 1'b0;
    end else begin
      s_psel      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      s_penable   <= (state_nxt == ACCESS);
      arb_busy    <= (state_nxt != IDLE);
      timeout_evt <= done_tmo;
      m0_pready   <= 1'b0;
      m0_prdata   <= '0;
      m0_pslverr  <= 1'b0;
      m1_pready   <= 1'b0;
      m1_prdata   <= '0;
      m1_pslverr  <= 1'b0;

      if (grant) begin
        s_paddr    <= pick ? m1_paddr  : m0_paddr;
        s_pwrite   <= pick ? m1_pwrite : m0_pwrite;
        s_pwdata   <= pick ? m1_pwdata : m0_pwdata;
        arb_gnt    <= pick;
        last_grant <= pick;
      end

      if (state == SETUP)       cnt <= '0;
      else if (state == ACCESS) cnt <= cnt + CNT_W'(1);

      if (done_ok || done_tmo) begin
        if (arb_gnt) begin
          m1_pready  <= 1'b1;
          m1_prdata  <= rsp_rdata;
          m1_pslverr <= rsp_err;
        end else begin
          m0_pready  <= 1'b1;
          m0_prdata  <= rsp_rdata;
          m0_pslverr <= rsp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_cfs_apb_arb.sv
// Scoreboard bench for cfs_apb_arb: queued requester transfers, reactive completer model,
// per-scenario cycle-profile checks.
`timescale 1ns/1ps
module tb_cfs_apb_arb;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TMO = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } xfer_t;

  logic pclk = 1'b0;
  logic presetn = 1'b0;

  logic [AW-1:0] paddr   [2];
  logic          pwrite  [2];
  logic          psel    [2];
  logic          penable [2];
  logic [DW-1:0] pwdata  [2];

  logic          m0_pready, m1_pready, m0_pslverr, m1_pslverr;
  logic [DW-1:0] m0_prdata, m1_prdata;
  logic          pready_v  [2];
  logic [DW-1:0] prdata_v  [2];
  logic          pslverr_v [2];
  assign pready_v[0]  = m0_pready;
  assign pready_v[1]  = m1_pready;
  assign prdata_v[0]  = m0_prdata;
  assign prdata_v[1]  = m1_prdata;
  assign pslverr_v[0] = m0_pslverr;
  assign pslverr_v[1] = m1_pslverr;

  logic [AW-1:0] s_paddr;
  logic [DW-1:0] s_pwdata;
  logic          s_pwrite, s_psel, s_penable;
  logic          s_pready = 1'b0;
  logic [DW-1:0] s_prdata = '0;
  logic          s_pslverr = 1'b0;
  logic          arb_busy, arb_gnt, timeout_evt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tmo_count = 0;
  int last_done_cyc = 0;
  int lat   [2];
  int start [2];
  bit active [2];

  int slv_wait = 0;
  bit slv_err  = 1'b0;
  bit slv_hang = 1'b0;

  xfer_t cmd_q0[$], cmd_q1[$], exp_q0[$], exp_q1[$];
  int order_q[$];

  cfs_apb_arb #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .m0_paddr(paddr[0]), .m0_pwrite(pwrite[0]), .m0_psel(psel[0]), .m0_penable(penable[0]),
    .m0_pwdata(pwdata[0]), .m0_pready(m0_pready), .m0_prdata(m0_prdata), .m0_pslverr(m0_pslverr),
    .m1_paddr(paddr[1]), .m1_pwrite(pwrite[1]), .m1_psel(psel[1]), .m1_penable(penable[1]),
    .m1_pwdata(pwdata[1]), .m1_pready(m1_pready), .m1_prdata(m1_prdata), .m1_pslverr(m1_pslverr),
    .s_paddr(s_paddr), .s_pwrite(s_pwrite), .s_psel(s_psel), .s_penable(s_penable),
    .s_pwdata(s_pwdata), .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .arb_busy(arb_busy), .arb_gnt(arb_gnt), .timeout_evt(timeout_evt)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;
  always @(negedge pclk) if (presetn && timeout_evt) tmo_count <= tmo_count + 1;

  function automatic logic [DW-1:0] slave_rdata(input logic [AW-1:0] a);
    case (a)
      16'h000C: return 32'h0003_0207;
      16'h00F0: return 32'h0000_001F;
      default:  return {16'hA5A5, a};
    endcase
  endfunction

  function automatic int cmd_size(input int m);
    return (m == 0) ? cmd_q0.size() : cmd_q1.size();
  endfunction
  function automatic int exp_size(input int m);
    return (m == 0) ? exp_q0.size() : exp_q1.size();
  endfunction
  function automatic xfer_t cmd_pop(input int m);
    if (m == 0) return cmd_q0.pop_front();
    return cmd_q1.pop_front();
  endfunction
  function automatic xfer_t exp_pop(input int m);
    if (m == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction
  function automatic void exp_push(input int m, input xfer_t x);
    if (m == 0) exp_q0.push_back(x);
    else        exp_q1.push_back(x);
  endfunction

  task automatic push_cmd(input int m, input logic [AW-1:0] a, input logic w,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic er);
    xfer_t x;
    x.addr = a; x.write = w; x.wdata = wd; x.rdata = rd; x.err = er;
    if (m == 0) cmd_q0.push_back(x);
    else        cmd_q1.push_back(x);
    order_q.push_back(m);
  endtask

  // Completer model: pready one cycle after psel&penable, plus slv_wait extra wait states.
  initial begin
    int acc;
    acc = 0;
    forever begin
      @(negedge pclk);
      if (s_pready) begin
        s_pready = 1'b0; s_prdata = '0; s_pslverr = 1'b0; acc = 0;
      end else if (presetn && s_psel && s_penable) begin
        if (!slv_hang && acc == slv_wait + 1) begin
          s_pready = 1'b1; s_prdata = slave_rdata(s_paddr); s_pslverr = slv_err;
        end else acc++;
      end else acc = 0;
    end
  end

  // Requester drivers and response scoreboard.
  initial begin
    xfer_t x;
    for (int m = 0; m < 2; m++) begin
      psel[m] = 1'b0; penable[m] = 1'b0; pwrite[m] = 1'b0; paddr[m] = '0; pwdata[m] = '0;
      active[m] = 1'b0; lat[m] = 0; start[m] = 0;
    end
    forever begin
      @(negedge pclk);
      for (int m = 0; m < 2; m++) begin
        if (!presetn) begin
          active[m] = 1'b0; psel[m] = 1'b0; penable[m] = 1'b0;
        end else begin
          if (pready_v[m]) begin
            checks++;
            if (!active[m] || exp_size(m) == 0) begin
              errors++;
              $display("FAIL unexpected_pready m%0d got=1 exp=0", m);
            end else begin
              x = exp_pop(m);
              checks++;
              if (prdata_v[m] !== x.rdata) begin
                errors++; $display("FAIL m%0d_prdata got=%h exp=%h", m, prdata_v[m], x.rdata);
              end
              checks++;
              if (pslverr_v[m] !== x.err) begin
                errors++; $display("FAIL m%0d_pslverr got=%b exp=%b", m, pslverr_v[m], x.err);
              end
              checks++;
              if ({s_paddr, s_pwrite, s_pwdata} !== {x.addr, x.write, x.wdata}) begin
                errors++;
                $display("FAIL s_capture m%0d got=%h/%b/%h exp=%h/%b/%h", m, s_paddr, s_pwrite,
                         s_pwdata, x.addr, x.write, x.wdata);
              end
              checks++;
              if (arb_gnt !== m[0]) begin
                errors++; $display("FAIL arb_gnt got=%b exp=%0d", arb_gnt, m);
              end
              checks++;
              if (pready_v[1-m] !== 1'b0) begin
                errors++; $display("FAIL other_pready m%0d got=%b exp=0", 1-m, pready_v[1-m]);
              end
              checks++;
              if (order_q.size() == 0) begin
                errors++; $display("FAIL grant_order got=m%0d exp=none", m);
              end else if (order_q[0] != m) begin
                errors++; $display("FAIL grant_order got=m%0d exp=m%0d", m, order_q[0]);
                void'(order_q.pop_front());
              end else void'(order_q.pop_front());
              lat[m] = cyc - start[m];
              last_done_cyc = cyc;
            end
            active[m] = 1'b0; psel[m] = 1'b0; penable[m] = 1'b0;
          end else begin
            checks++;
            if (prdata_v[m] !== '0 || pslverr_v[m] !== 1'b0) begin
              errors++;
              $display("FAIL m%0d_idle_resp got=%h/%b exp=0/0", m, prdata_v[m], pslverr_v[m]);
            end
          end
          if (!active[m] && cmd_size(m) != 0) begin
            x = cmd_pop(m);
            paddr[m] = x.addr; pwrite[m] = x.write; pwdata[m] = x.wdata;
            psel[m] = 1'b1; penable[m] = 1'b0; active[m] = 1'b1; start[m] = cyc;
            exp_push(m, x);
          end else if (active[m]) penable[m] = 1'b1;
        end
      end
    end
  end

  task automatic clear_queues();
    cmd_q0.delete(); cmd_q1.delete(); exp_q0.delete(); exp_q1.delete(); order_q.delete();
  endtask

  task automatic apply_reset();
    presetn = 1'b0;
    clear_queues();
    repeat (2) @(negedge pclk);
    #1 presetn = 1'b1;
    @(posedge pclk); #1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while ((cmd_q0.size() != 0 || cmd_q1.size() != 0 || active[0] || active[1]) && n < budget) begin
      @(negedge pclk); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++; $display("FAIL %s_done got=busy exp=idle within %0d cycles", name, budget);
    end
    @(posedge pclk); #1;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    repeat (2) @(negedge pclk);
    checks++;
    if ({s_psel, s_penable, s_pwrite, arb_busy, arb_gnt, timeout_evt, m0_pready, m1_pready,
         m0_pslverr, m1_pslverr, s_paddr, s_pwdata, m0_prdata, m1_prdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got=nonzero exp=0 (s_psel=%b busy=%b gnt=%b)",
                         s_psel, arb_busy, arb_gnt);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    logic [5:0] ps, pe, pr, bz;
    slv_wait = 0; slv_err = 1'b0; slv_hang = 1'b0;
    push_cmd(0, 16'h000C, 1'b0, 32'hDEAD_BEEF, 32'h0003_0207, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      ps[i] = s_psel; pe[i] = s_penable; pr[i] = m0_pready; bz[i] = arb_busy;
    end
    checks++;
    if (ps !== 6'b001110) begin errors++; $display("FAIL read_s_psel got=%b exp=001110", ps); end
    checks++;
    if (pe !== 6'b001100) begin errors++; $display("FAIL read_s_penable got=%b exp=001100", pe); end
    checks++;
    if (pr !== 6'b010000) begin errors++; $display("FAIL read_m0_pready got=%b exp=010000", pr); end
    checks++;
    if (bz !== 6'b011110) begin errors++; $display("FAIL read_busy got=%b exp=011110", bz); end
    wait_done(20, "read");
    checks++;
    if (lat[0] != 4) begin errors++; $display("FAIL read_latency got=%0d exp=4", lat[0]); end
  endtask

  task automatic test_back_to_back();
    int c0;
    apply_reset();
    slv_wait = 0; slv_err = 1'b0; slv_hang = 1'b0;
    c0 = cyc;
    push_cmd(0, 16'h0000, 1'b1, 32'h0000_0001, '0, 1'b0);
    push_cmd(1, 16'h00F0, 1'b0, 32'h1111_2222, 32'h0000_001F, 1'b0);
    for (int i = 1; i < 4; i++) begin
      push_cmd(0, 16'(16'h0010 + 4 * i), 1'b0, 32'(i), slave_rdata(16'(16'h0010 + 4 * i)), 1'b0);
      push_cmd(1, 16'(16'h0020 + 4 * i), 1'b1, 32'(32'hC0DE_0000 + i), '0, 1'b0);
    end
    wait_done(100, "contention");
    checks++;
    if (order_q.size() != 0) begin
      errors++; $display("FAIL contention_left got=%0d exp=0", order_q.size());
    end
    checks++;
    if (last_done_cyc - c0 != 39) begin
      errors++; $display("FAIL contention_cycles got=%0d exp=39", last_done_cyc - c0);
    end
  endtask

  task automatic test_write_err();
    slv_wait = 0; slv_err = 1'b1; slv_hang = 1'b0;
    push_cmd(1, 16'h000C, 1'b1, 32'h0000_0055, '0, 1'b1);
    wait_done(20, "write_err");
    checks++;
    if (lat[1] != 4) begin errors++; $display("FAIL write_err_latency got=%0d exp=4", lat[1]); end
    slv_err = 1'b0;
  endtask

  task automatic test_timeout();
    logic [21:0] ps, te;
    int t0;
    slv_wait = 0; slv_err = 1'b0; slv_hang = 1'b1;
    t0 = tmo_count;
    push_cmd(0, 16'h0004, 1'b0, 32'h0, '0, 1'b1);
    for (int i = 0; i < 22; i++) begin
      @(negedge pclk);
      ps[i] = s_psel; te[i] = timeout_evt;
    end
    checks++;
    if (te !== 22'h040000) begin errors++; $display("FAIL timeout_evt got=%h exp=040000", te); end
    checks++;
    if (ps !== 22'h03FFFE) begin errors++; $display("FAIL timeout_s_psel got=%h exp=03fffe", ps); end
    wait_done(20, "timeout");
    checks++;
    if (lat[0] != 18) begin errors++; $display("FAIL timeout_latency got=%0d exp=18", lat[0]); end
    slv_hang = 1'b0;
    push_cmd(1, 16'h00F0, 1'b0, 32'h0, 32'h0000_001F, 1'b0);
    wait_done(20, "after_timeout");
    checks++;
    if (lat[1] != 4) begin errors++; $display("FAIL after_timeout_latency got=%0d exp=4", lat[1]); end
    checks++;
    if (tmo_count - t0 != 1) begin
      errors++; $display("FAIL timeout_pulses got=%0d exp=1", tmo_count - t0);
    end
  endtask

  task automatic test_wait_states();
    int t0;
    slv_wait = 2; slv_err = 1'b1; slv_hang = 1'b0;
    t0 = tmo_count;
    push_cmd(0, 16'h0000, 1'b1, 32'h0000_0000, '0, 1'b1);
    wait_done(30, "wait_states");
    checks++;
    if (lat[0] != 6) begin errors++; $display("FAIL wait_latency got=%0d exp=6", lat[0]); end
    checks++;
    if (tmo_count != t0) begin errors++; $display("FAIL wait_timeout got=%0d exp=0", tmo_count - t0); end
    slv_wait = 0; slv_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    slv_hang = 1'b1;
    push_cmd(0, 16'h0008, 1'b0, 32'h0, '0, 1'b1);
    n = 0;
    while (!s_penable && n < 20) begin @(negedge pclk); n++; end
    checks++;
    if (!s_penable) begin errors++; $display("FAIL reset_mid_access got=%b exp=1", s_penable); end
    @(posedge pclk); #2 presetn = 1'b0;
    clear_queues();
    #1;
    checks++;
    if ({s_psel, s_penable, arb_busy, arb_gnt, m0_pready, m1_pready, s_paddr} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs got=psel%b pen%b busy%b gnt%b exp=0",
                         s_psel, s_penable, arb_busy, arb_gnt);
    end
    repeat (2) @(negedge pclk);
    #1 presetn = 1'b1;
    slv_hang = 1'b0;
    @(posedge pclk); #1;
    push_cmd(0, 16'h000C, 1'b0, 32'h0, 32'h0003_0207, 1'b0);
    push_cmd(1, 16'h00F0, 1'b0, 32'h0, 32'h0000_001F, 1'b0);
    wait_done(40, "reset_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_err();
    test_timeout();
    test_wait_states();
    test_reset_mid();
    repeat (3) @(negedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfs_apb_arb.md
Name: cfs_apb_arb

Overview:
Two-requester APB arbiter in front of the Aligner register block's single APB completer port. Two upstream APB requesters (m0, m1; e.g. CPU and debug/DMA) share the downstream APB slave. The block grants one transfer at a time round-robin, runs the downstream SETUP/ACCESS sequence itself and returns the completer response to the granted requester only. A watchdog terminates downstream transfers that never complete.

Parameters:
APB_ADDR_WIDTH, 16, address width on all three APB ports
APB_DATA_WIDTH, 32, data width on all three APB ports
TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for s_pready (legal range >=2); counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
pclk  in  1  clock
presetn  in  1  reset, asynchronous, active-low
m0_paddr / m1_paddr  in  APB_ADDR_WIDTH  requester address
m0_pwrite / m1_pwrite  in  1  requester direction (1 = write)
m0_psel / m1_psel  in  1  requester select
m0_penable / m1_penable  in  1  requester access phase
m0_pwdata / m1_pwdata  in  APB_DATA_WIDTH  requester write data
m0_pready / m1_pready  out  1  transfer complete, one-cycle pulse
m0_prdata / m1_prdata  out  APB_DATA_WIDTH  read data, valid with pready, else 0
m0_pslverr / m1_pslverr  out  1  error, valid with pready, else 0
s_paddr  out  APB_ADDR_WIDTH  downstream address
s_pwrite  out  1  downstream direction
s_psel  out  1  downstream select
s_penable  out  1  downstream access phase
s_pwdata  out  APB_DATA_WIDTH  downstream write data
s_pready  in  1  downstream ready
s_prdata  in  APB_DATA_WIDTH  downstream read data
s_pslverr  in  1  downstream error
arb_busy  out  1  1 while state != IDLE
arb_gnt  out  1  current or last granted requester (0 = m0)
timeout_evt  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- All outputs registered. Reset values: every output 0. Internally state=IDLE, last_grant=1 so m0 wins the first tie, timeout counter 0.
- FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: a request is mX_psel=1; penable is ignored. With one requester, grant it. With both, grant the requester != last_grant. On grant, capture that requester's paddr/pwrite/pwdata into s_* registers, set arb_gnt and last_grant, then go to SETUP. With no request, stay in IDLE with s_psel=0.
- SETUP, one cycle: s_psel=1, s_penable=0. Clear the counter, then go to ACCESS.
- ACCESS: s_psel=1, s_penable=1, counter increments each cycle.
  - s_pready=1: capture s_prdata (forced to 0 for writes) and s_pslverr; drop s_psel/s_penable at the next edge; go to RESP.
  - Counter reaches TIMEOUT_CYCLES with no s_pready: response is pslverr=1, prdata=0; pulse timeout_evt for one cycle; drop s_psel/s_penable; go to RESP.
- RESP, one cycle: granted mX_pready=1 with the captured prdata/pslverr. The other requester's outputs stay 0. Next state is IDLE; arb_gnt holds its value.
- The non-granted requester sees pready=0 throughout and its stalled transfer stays pending. Requesters hold psel/paddr/pwdata stable until their pready (standard APB).
- Latency with the register block (pready registered one cycle after psel&penable): requester psel in cycle 0 -> s_psel cycles 1-3, s_penable cycles 2-3, mX_pready in cycle 4. Each extra slave wait state adds one cycle.
- Back-to-back: a new request sampled in IDLE the cycle after RESP is granted with no idle gap beyond the IDLE cycle. Under continuous contention grants alternate m0, m1, m0, ...
- Requester drops psel mid-transfer (protocol violation): the downstream transfer still completes and the pready pulse is still issued; the arbiter does not abort.
- Captured s_* signals are not updated after the grant, so requester changes mid-transfer have no downstream effect.
- Reset mid-operation: immediate return to reset values, so s_psel drops asynchronously. After release, arbitration restarts with m0 preferred.

Test Plan:
- m0 reads 0x000C, slave returns 0x0003_0207 with one-cycle pready -> s_psel cycles 1-3, s_penable 2-3, m0_pready=1 in cycle 4 with m0_prdata=0x0003_0207, m0_pslverr=0, m1_* all 0.
- m0 writes 0x0000 with 0x0000_0001 and m1 reads 0x00F0, both psel in the same cycle after reset -> m0 is served first with m1_pready held 0; m1 then completes with prdata=0x0000_001F. Both requesting continuously for 4 transfers each -> grant order m0,m1,m0,m1,...
- m1 writes 0x000C, slave returns pslverr=1 -> m1_pready=1 with m1_pslverr=1, m1_prdata=0; m0 outputs unaffected.
- Slave never asserts pready, TIMEOUT_CYCLES=16 -> after 16 ACCESS cycles timeout_evt pulses for 1 cycle, m0_pready=1, m0_pslverr=1, m0_prdata=0; s_psel=0 the next cycle; a following m1 request is served normally.
- Slave inserts 2 extra wait states (illegal CTRL write, size=0) -> m0_pready arrives 2 cycles later with the slave's pslverr; no timeout.
- presetn asserted during ACCESS -> all outputs 0 immediately. After release, simultaneous m0/m1 requests -> m0 granted first.
